uart_rx_frame: RTL and testbench

UART_RX_FRAME -- requirements
Module: uart_rx_frame

---
 rtl/uart_pkg.sv | 21 ++
 rtl/rx_sync.sv | 25 ++
 rtl/uart_rx_frame.sv | 149 ++++++++++++++
 tb/tb_uart_rx_frame.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM encoding, default frame
// width and the half-bit period of the external tick generator.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int DATA_BITS_DEFAULT = 8;
  localparam int HALF_BIT_CLKS     = 2601;
  localparam int TICK_CNT_W        = 5;

  // Half-bit tick number on which the n-th data bit (1-based) is centred.
  function automatic logic [TICK_CNT_W-1:0] data_tick(input int n);
    return TICK_CNT_W'(2 * n + 1);
  endfunction

endpackage

// File: rtl/rx_sync.sv
// Multi-stage synchroniser for the asynchronous serial line; resets to the
// idle-high level so a reset never looks like a start bit.
module rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic serial,
  output logic synced
);

  logic [SYNC_STAGES-1:0] stages;

  // Shift the raw line into the chain, oldest sample at the MSB.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stages <= {SYNC_STAGES{1'b1}};
    end else begin
      stages <= SYNC_STAGES'({stages, serial});
    end
  end

  assign synced = stages[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_frame.sv
// UART frame receiver timed by an external half-bit tick generator: detects the
// start edge, samples each bit at its centre and checks the stop bit.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = DATA_BITS_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 SystemClock,
  input  logic                 ResetTimer,
  input  logic                 RxSerial,
  input  logic                 NextBit,
  output logic                 TimerRun,
  output logic [DATA_BITS-1:0] RxData,
  output logic                 RxValid,
  output logic                 FrameError,
  output logic                 Busy
);

  localparam logic [TICK_CNT_W-1:0] LAST_DATA_TICK = data_tick(DATA_BITS);
  localparam logic [TICK_CNT_W-1:0] STOP_TICK      = TICK_CNT_W'(2 * DATA_BITS + 3);

  rx_state_t              state, state_nxt;
  logic                   rx_s;
  logic                   nb_d;
  logic                   tick;
  logic [TICK_CNT_W-1:0]  tick_cnt, tick_cnt_nxt, tick_num;
  logic [DATA_BITS-1:0]   shift, shift_nxt, rx_data_nxt;
  logic                   timer_run_nxt, rx_valid_nxt, frame_error_nxt;

  rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rx_sync (
    .clk    (SystemClock),
    .rst_n  (ResetTimer),
    .serial (RxSerial),
    .synced (rx_s)
  );

  // Either toggle direction of NextBit is one half-bit tick.
  assign tick     = NextBit ^ nb_d;
  assign tick_num = tick_cnt + TICK_CNT_W'(1);
  assign Busy     = (state != IDLE);

  // Next-state logic and next values of every registered output.
  always_comb begin
    state_nxt       = state;
    tick_cnt_nxt    = tick_cnt;
    shift_nxt       = shift;
    rx_data_nxt     = RxData;
    timer_run_nxt   = TimerRun;
    rx_valid_nxt    = 1'b0;
    frame_error_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nxt     = START;
          timer_run_nxt = 1'b1;
          tick_cnt_nxt  = '0;
        end else begin
          timer_run_nxt = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          tick_cnt_nxt = tick_num;
          if (rx_s) begin
            state_nxt     = IDLE;
            timer_run_nxt = 1'b0;
          end else begin
            state_nxt = DATA;
          end
        end else begin
          state_nxt = START;
        end
      end
      DATA: begin
        if (tick) begin
          tick_cnt_nxt = tick_num;
          // Odd ticks land mid-bit; even ticks mark bit boundaries.
          if (tick_num[0]) begin
            shift_nxt = {rx_s, shift[DATA_BITS-1:1]};
            if (tick_num == LAST_DATA_TICK) begin
              state_nxt = STOP;
            end else begin
              state_nxt = DATA;
            end
          end else begin
            state_nxt = DATA;
          end
        end else begin
          state_nxt = DATA;
        end
      end
      STOP: begin
        if (tick) begin
          tick_cnt_nxt = tick_num;
          if (tick_num == STOP_TICK) begin
            state_nxt     = IDLE;
            timer_run_nxt = 1'b0;
            if (rx_s) begin
              rx_data_nxt  = shift;
              rx_valid_nxt = 1'b1;
            end else begin
              frame_error_nxt = 1'b1;
            end
          end else begin
            state_nxt = STOP;
          end
        end else begin
          state_nxt = STOP;
        end
      end
      default: begin
        state_nxt     = IDLE;
        timer_run_nxt = 1'b0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge SystemClock) begin
    if (!ResetTimer) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath, output registers and tick edge detector (held clear while the generator is stopped).
  always_ff @(posedge SystemClock) begin
    if (!ResetTimer) begin
      tick_cnt   <= '0;
      shift      <= '0;
      RxData     <= '0;
      RxValid    <= 1'b0;
      FrameError <= 1'b0;
      TimerRun   <= 1'b0;
      nb_d       <= 1'b0;
    end else begin
      tick_cnt   <= tick_cnt_nxt;
      shift      <= shift_nxt;
      RxData     <= rx_data_nxt;
      RxValid    <= rx_valid_nxt;
      FrameError <= frame_error_nxt;
      TimerRun   <= timer_run_nxt;
      nb_d       <= TimerRun ? NextBit : 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame: models the upstream tick generator,
// drives serial frames and compares received words against a frame-level model.
module tb_uart_rx_frame;

  logic       SystemClock = 1'b0;
  logic       ResetTimer  = 1'b0;
  logic       RxSerial    = 1'b1;
  logic       NextBit     = 1'b0;
  logic       TimerRun;
  logic [7:0] RxData;
  logic       RxValid;
  logic       FrameError;
  logic       Busy;

  int errors = 0;
  int checks = 0;
  int half_bit = 2601;
  int gen_cnt = 0;

  logic [7:0] got_q[$];
  int         ferr_cnt = 0;
  int         both_cnt = 0;
  int         long_cnt = 0;
  logic       prev_valid = 1'b0;
  logic       prev_ferr = 1'b0;
  logic [7:0] exp_last = 8'h00;

  uart_rx_frame #(.DATA_BITS(8), .SYNC_STAGES(2)) dut (
    .SystemClock (SystemClock),
    .ResetTimer  (ResetTimer),
    .RxSerial    (RxSerial),
    .NextBit     (NextBit),
    .TimerRun    (TimerRun),
    .RxData      (RxData),
    .RxValid     (RxValid),
    .FrameError  (FrameError),
    .Busy        (Busy)
  );

  always #5 SystemClock = ~SystemClock;

  // Upstream tick generator: toggles NextBit every half_bit clocks while released.
  always @(posedge SystemClock) begin
    if (TimerRun !== 1'b1) begin
      gen_cnt <= 0;
      NextBit <= 1'b0;
    end else if (gen_cnt == half_bit - 1) begin
      gen_cnt <= 0;
      NextBit <= ~NextBit;
    end else begin
      gen_cnt <= gen_cnt + 1;
    end
  end

  // Output monitor: collects received words and pulse statistics.
  always @(negedge SystemClock) begin
    if (RxValid === 1'b1) got_q.push_back(RxData);
    if (FrameError === 1'b1) ferr_cnt <= ferr_cnt + 1;
    if (RxValid === 1'b1 && FrameError === 1'b1) both_cnt <= both_cnt + 1;
    if ((RxValid === 1'b1 && prev_valid) || (FrameError === 1'b1 && prev_ferr))
      long_cnt <= long_cnt + 1;
    prev_valid <= (RxValid === 1'b1);
    prev_ferr  <= (FrameError === 1'b1);
  end

  // Drive one frame {stop, data LSB first, start}; abort_at > 0 stops early.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int abort_at);
    logic [9:0] frame;
    frame = {stop, d, 1'b0};
    for (int c = 0; c < 20 * half_bit; c++) begin
      if (abort_at > 0 && c >= abort_at) break;
      RxSerial = frame[c / (2 * half_bit)];
      @(negedge SystemClock);
    end
    RxSerial = 1'b1;
  endtask

  task automatic idle_bits(input int n);
    RxSerial = 1'b1;
    repeat (n * 2 * half_bit) @(negedge SystemClock);
  endtask

  task automatic test_reset;
    ResetTimer = 1'b0;
    RxSerial   = 1'b1;
    repeat (3) @(negedge SystemClock);
    checks++; if (TimerRun !== 1'b0) begin errors++; $display("FAIL reset_timerrun: got %b want 0", TimerRun); end
    checks++; if (RxData !== 8'h00) begin errors++; $display("FAIL reset_rxdata: got %h want 00", RxData); end
    checks++; if (RxValid !== 1'b0) begin errors++; $display("FAIL reset_rxvalid: got %b want 0", RxValid); end
    checks++; if (FrameError !== 1'b0) begin errors++; $display("FAIL reset_frameerror: got %b want 0", FrameError); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", Busy); end
    ResetTimer = 1'b1;
    repeat (4) @(negedge SystemClock);
  endtask

  task automatic test_good_frame;
    int vb, fb;
    half_bit = 2601;
    vb = got_q.size();
    fb = ferr_cnt;
    send_frame(8'hA5, 1'b1, 0);
    repeat (20) @(negedge SystemClock);
    exp_last = 8'hA5;
    checks++;
    if (got_q.size() != vb + 1) begin
      errors++; $display("FAIL good_count: got %0d pulses want 1", got_q.size() - vb);
    end else begin
      checks++; if (got_q[vb] !== 8'hA5) begin errors++; $display("FAIL good_word: got %h want a5", got_q[vb]); end
    end
    checks++; if (RxData !== 8'hA5) begin errors++; $display("FAIL good_rxdata: got %h want a5", RxData); end
    checks++; if (ferr_cnt != fb) begin errors++; $display("FAIL good_ferr: got %0d want 0", ferr_cnt - fb); end
    checks++; if (long_cnt != 0) begin errors++; $display("FAIL good_pulse_width: got %0d long pulses want 0", long_cnt); end
    checks++; if (Busy !== 1'b0 || TimerRun !== 1'b0) begin errors++; $display("FAIL good_idle: got busy=%b run=%b want 0 0", Busy, TimerRun); end
  endtask

  task automatic test_glitch;
    int vb, fb, k;
    half_bit = 2601;
    vb = got_q.size();
    fb = ferr_cnt;
    k  = 0;
    RxSerial = 1'b0;
    repeat (1000) begin @(negedge SystemClock); k++; end
    checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL glitch_start: got busy=%b want 1", Busy); end
    RxSerial = 1'b1;
    // 2602 clocks plus synchroniser and register latency.
    while ((Busy !== 1'b0 || TimerRun !== 1'b0) && k < 2602 + 6) begin
      @(negedge SystemClock); k++;
    end
    checks++; if (Busy !== 1'b0 || TimerRun !== 1'b0) begin errors++; $display("FAIL glitch_idle: got busy=%b run=%b after %0d clocks want 0 0", Busy, TimerRun, k); end
    half_bit = 16;
    idle_bits(2);
    checks++; if (got_q.size() != vb) begin errors++; $display("FAIL glitch_valid: got %0d pulses want 0", got_q.size() - vb); end
    checks++; if (ferr_cnt != fb) begin errors++; $display("FAIL glitch_ferr: got %0d pulses want 0", ferr_cnt - fb); end
  endtask

  task automatic test_frame_error;
    int vb, fb;
    half_bit = 16;
    vb = got_q.size();
    fb = ferr_cnt;
    send_frame(8'h3C, 1'b0, 0);
    idle_bits(3);
    checks++; if (ferr_cnt != fb + 1) begin errors++; $display("FAIL ferr_count: got %0d want 1", ferr_cnt - fb); end
    checks++; if (got_q.size() != vb) begin errors++; $display("FAIL ferr_valid: got %0d pulses want 0", got_q.size() - vb); end
    checks++; if (RxData !== exp_last) begin errors++; $display("FAIL ferr_rxdata: got %h want %h", RxData, exp_last); end
    checks++; if (long_cnt != 0) begin errors++; $display("FAIL ferr_pulse_width: got %0d long pulses want 0", long_cnt); end
  endtask

  task automatic test_back_to_back;
    int vb;
    vb = got_q.size();
    send_frame(8'h00, 1'b1, 0);
    send_frame(8'hFF, 1'b1, 0);
    idle_bits(2);
    exp_last = 8'hFF;
    checks++;
    if (got_q.size() != vb + 2) begin
      errors++; $display("FAIL b2b_count: got %0d pulses want 2", got_q.size() - vb);
    end else begin
      checks++; if (got_q[vb] !== 8'h00) begin errors++; $display("FAIL b2b_first: got %h want 00", got_q[vb]); end
      checks++; if (got_q[vb+1] !== 8'hFF) begin errors++; $display("FAIL b2b_second: got %h want ff", got_q[vb+1]); end
    end
  endtask

  task automatic test_reset_mid_frame;
    int vb;
    vb = got_q.size();
    send_frame(8'hC3, 1'b1, 11 * half_bit);
    ResetTimer = 1'b0;
    @(negedge SystemClock);
    checks++; if (RxData !== 8'h00) begin errors++; $display("FAIL midreset_rxdata: got %h want 00", RxData); end
    checks++; if (TimerRun !== 1'b0 || Busy !== 1'b0) begin errors++; $display("FAIL midreset_idle: got run=%b busy=%b want 0 0", TimerRun, Busy); end
    checks++; if (RxValid !== 1'b0 || FrameError !== 1'b0) begin errors++; $display("FAIL midreset_pulses: got v=%b fe=%b want 0 0", RxValid, FrameError); end
    ResetTimer = 1'b1;
    exp_last = 8'h00;
    idle_bits(2);
    checks++; if (got_q.size() != vb) begin errors++; $display("FAIL midreset_abandon: got %0d pulses want 0", got_q.size() - vb); end
    send_frame(8'h5A, 1'b1, 0);
    idle_bits(2);
    exp_last = 8'h5A;
    checks++;
    if (got_q.size() != vb + 1) begin
      errors++; $display("FAIL after_reset_count: got %0d pulses want 1", got_q.size() - vb);
    end else begin
      checks++; if (got_q[vb] !== 8'h5A) begin errors++; $display("FAIL after_reset_word: got %h want 5a", got_q[vb]); end
    end
    checks++; if (RxData !== 8'h5A) begin errors++; $display("FAIL after_reset_rxdata: got %h want 5a", RxData); end
  endtask

  task automatic test_random;
    int         vb, fb, exp_ferr;
    logic [7:0] exp_q[$];
    logic [7:0] d;
    logic       stop;
    vb = got_q.size();
    fb = ferr_cnt;
    exp_ferr = 0;
    for (int i = 0; i < 8; i++) begin
      d    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 3) != 0);
      send_frame(d, stop, 0);
      if (stop) begin
        exp_q.push_back(d);
        exp_last = d;
        idle_bits(int'($urandom_range(0, 2)));
      end else begin
        exp_ferr++;
        idle_bits(1 + int'($urandom_range(0, 1)));
      end
    end
    idle_bits(2);
    checks++;
    if (got_q.size() != vb + exp_q.size()) begin
      errors++; $display("FAIL rand_count: got %0d pulses want %0d", got_q.size() - vb, exp_q.size());
    end else begin
      for (int j = 0; j < exp_q.size(); j++) begin
        checks++;
        if (got_q[vb+j] !== exp_q[j]) begin errors++; $display("FAIL rand_word%0d: got %h want %h", j, got_q[vb+j], exp_q[j]); end
      end
    end
    checks++; if (ferr_cnt != fb + exp_ferr) begin errors++; $display("FAIL rand_ferr: got %0d want %0d", ferr_cnt - fb, exp_ferr); end
    checks++; if (RxData !== exp_last) begin errors++; $display("FAIL rand_rxdata: got %h want %h", RxData, exp_last); end
    checks++; if (both_cnt != 0) begin errors++; $display("FAIL valid_and_ferr_together: got %0d want 0", both_cnt); end
    checks++; if (long_cnt != 0) begin errors++; $display("FAIL pulse_width: got %0d long pulses want 0", long_cnt); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_glitch();
    test_frame_error();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
